// File: rtl/voice_scheduler.sv
// Time-multiplexed oscillator engine: one shared phase adder and waveform/attenuator
// walk all voices on each sample strobe and produce a saturated offset-binary sample.
module voice_scheduler #(
  parameter int NVOICES = 4,
  parameter int INC_W   = 9,
  localparam int VW     = $clog2(NVOICES)
) (
  input  logic             clk48,
  input  logic             rst,
  input  logic             sample_tick,
  input  logic             cfg_we,
  input  logic [VW-1:0]    cfg_voice,
  input  logic [1:0]       cfg_field,
  input  logic [INC_W-1:0] cfg_data,
  output logic             cfg_ready,
  output logic [15:0]      sample_out,
  output logic             sample_valid,
  output logic             busy,
  output logic             overrun
);

  localparam int NSLOT = 1 << VW;

  typedef enum logic [1:0] {IDLE, PH, MIX, DONE} state_t;

  // Handshake: a config write transfers on a clock edge where cfg_we and
  // cfg_ready are both high; the requester holds cfg_we and data until then.

  state_t             state;
  logic [VW-1:0]      vidx;
  logic signed [17:0] mix;

  logic [15:0]        phase [NSLOT];
  logic [INC_W-1:0]   inc   [NSLOT];
  logic [3:0]         vol   [NSLOT];
  logic [1:0]         wave  [NSLOT];

  logic [15:0]        p;
  logic [15:0]        tri_u;
  logic [15:0]        saw_u;
  logic signed [15:0] w;
  logic signed [17:0] w_ext;
  logic signed [17:0] shifted;
  logic [15:0]        sat;

  assign cfg_ready = (state == IDLE) & ~sample_tick;

  // The MIX step sees the phase already advanced by the preceding PH step.
  assign p     = phase[vidx];
  assign tri_u = p ^ {16{p[15]}};
  assign saw_u = {1'b0, p[15:1]};

  always_comb begin
    w = '0;
    case (wave[vidx])
      2'd0:    w = p[15] ? -16'sd16384 : 16'sd16383;
      2'd1:    w = $signed(tri_u - 16'd16384);
      2'd2:    w = $signed(saw_u - 16'd16384);
      default: w = '0;
    endcase
  end

  assign w_ext   = $signed({{2{w[15]}}, w});
  assign shifted = w_ext >>> vol[vidx];

  always_comb begin
    sat = mix[15:0];
    if (mix > 18'sd32767)
      sat = 16'h7FFF;
    else if (mix < -18'sd32768)
      sat = 16'h8000;
  end

  always_ff @(posedge clk48 or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      vidx         <= '0;
      mix          <= '0;
      sample_out   <= 16'h8000;
      sample_valid <= 1'b0;
      busy         <= 1'b0;
      overrun      <= 1'b0;
      for (int i = 0; i < NSLOT; i++) begin
        phase[i] <= '0;
        inc[i]   <= '0;
        vol[i]   <= 4'hF;
        wave[i]  <= 2'd3;
      end
    end else begin
      sample_valid <= 1'b0;
      busy         <= (state != IDLE);
      if (sample_tick && state != IDLE)
        overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (sample_tick) begin
            state <= PH;
            vidx  <= '0;
            mix   <= '0;
          end else if (cfg_we) begin
            case (cfg_field)
              2'd0:    inc[cfg_voice]  <= cfg_data;
              2'd1:    vol[cfg_voice]  <= cfg_data[3:0];
              2'd2:    wave[cfg_voice] <= cfg_data[1:0];
              default: ;
            endcase
          end
        end
        PH: begin
          phase[vidx] <= phase[vidx] + 16'(inc[vidx]);
          state       <= MIX;
        end
        MIX: begin
          mix <= mix + shifted;
          if (vidx == VW'(NVOICES - 1)) begin
            state <= DONE;
          end else begin
            vidx  <= vidx + 1'b1;
            state <= PH;
          end
        end
        DONE: begin
          sample_out   <= sat ^ 16'h8000;
          sample_valid <= 1'b1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_voice_scheduler.sv
// Bench for voice_scheduler: directed scenarios plus randomized config/tick traffic
// checked against an arithmetic reference model of the voice mix.
module tb_voice_scheduler;

  localparam int NV  = 4;
  localparam int IW  = 9;
  localparam int LAT = 2 * NV + 1;

  logic          clk48 = 1'b0;
  logic          rst = 1'b1;
  logic          sample_tick = 1'b0;
  logic          cfg_we = 1'b0;
  logic [1:0]    cfg_voice = '0;
  logic [1:0]    cfg_field = '0;
  logic [IW-1:0] cfg_data = '0;
  logic          cfg_ready;
  logic [15:0]   sample_out;
  logic          sample_valid;
  logic          busy;
  logic          overrun;

  int n_vec = 0;
  int n_err = 0;

  int m_phase [NV];
  int m_inc   [NV];
  int m_vol   [NV];
  int m_wave  [NV];
  logic [15:0] exp_q [$];

  voice_scheduler #(.NVOICES(NV), .INC_W(IW)) dut (
    .clk48(clk48), .rst(rst), .sample_tick(sample_tick), .cfg_we(cfg_we),
    .cfg_voice(cfg_voice), .cfg_field(cfg_field), .cfg_data(cfg_data),
    .cfg_ready(cfg_ready), .sample_out(sample_out), .sample_valid(sample_valid),
    .busy(busy), .overrun(overrun)
  );

  always #5 clk48 = ~clk48;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int v = 0; v < NV; v++) begin
      m_phase[v] = 0; m_inc[v] = 0; m_vol[v] = 15; m_wave[v] = 3;
    end
    exp_q.delete();
  endfunction

  // Advances every voice and returns the expected offset-binary sample.
  function automatic logic [15:0] model_tick();
    int mix, w, s;
    mix = 0;
    for (int v = 0; v < NV; v++) begin
      m_phase[v] = (m_phase[v] + m_inc[v]) % 65536;
      case (m_wave[v])
        0: w = (m_phase[v] >= 32768) ? -16384 : 16383;
        1: w = ((m_phase[v] >= 32768) ? (65535 - m_phase[v]) : m_phase[v]) - 16384;
        2: w = m_phase[v] / 2 - 16384;
        default: w = 0;
      endcase
      mix += (w >>> m_vol[v]);
    end
    s = (mix > 32767) ? 32767 : (mix < -32768) ? -32768 : mix;
    return 16'(s + 32768);
  endfunction

  task automatic cfg_write(input int v, input int f, input int d);
    int tmo;
    @(posedge clk48); #1;
    cfg_we = 1'b1; cfg_voice = 2'(v); cfg_field = 2'(f); cfg_data = IW'(d);
    tmo = 0;
    while (!cfg_ready && tmo < 40) begin
      @(posedge clk48); #1; tmo++;
    end
    if (tmo >= 40) check("cfg_ready_timeout", 32'(tmo), 32'd0);
    @(posedge clk48); #1;
    cfg_we = 1'b0;
    case (f)
      0: m_inc[v] = d % (1 << IW);
      1: m_vol[v] = d % 16;
      2: m_wave[v] = d % 4;
      default: ;
    endcase
  endtask

  task automatic do_tick();
    int cnt;
    bit got;
    logic [15:0] prev;
    prev = sample_out;
    @(posedge clk48); #1;
    sample_tick = 1'b1;
    exp_q.push_back(model_tick());
    @(posedge clk48); #1;
    sample_tick = 1'b0;
    check("ready_low_in_seq", 32'(cfg_ready), 32'd0);
    cnt = 0; got = 0;
    while (cnt < 20 && !got) begin
      @(posedge clk48); #1; cnt++;
      if (cnt == 1) begin
        check("busy_rise", 32'(busy), 32'd1);
        check("sample_hold", 32'(sample_out), 32'(prev));
      end
      if (sample_valid) got = 1;
    end
    check("valid_latency", 32'(cnt), 32'(LAT));
    if (got && exp_q.size() > 0) check("sample_out", 32'(sample_out), 32'(exp_q.pop_front()));
    else if (exp_q.size() > 0) void'(exp_q.pop_front());
    @(posedge clk48); #1;
    check("valid_pulse", 32'(sample_valid), 32'd0);
    check("busy_fall", 32'(busy), 32'd0);
    check("ready_idle", 32'(cfg_ready), 32'd1);
  endtask

  task automatic do_reset();
    @(posedge clk48); #1;
    rst = 1'b1;
    #2;
    check("rst_sample_out", 32'(sample_out), 32'h8000);
    check("rst_valid", 32'(sample_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_ready", 32'(cfg_ready), 32'd1);
    @(posedge clk48); #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    int n, waited;
    bit seen;
    model_reset();
    #12;
    check("init_sample_out", 32'(sample_out), 32'h8000);
    check("init_busy", 32'(busy), 32'd0);
    check("init_ready", 32'(cfg_ready), 32'd1);
    @(posedge clk48); #1;
    rst = 1'b0;

    // All voices silent, ticks spaced 1024 cycles.
    for (int i = 0; i < 3; i++) begin
      do_tick();
      check("silent_overrun", 32'(overrun), 32'd0);
      repeat (1024 - LAT - 3) @(posedge clk48);
    end

    // Single square voice, then attenuation.
    cfg_write(0, 0, 'h100); cfg_write(0, 1, 0); cfg_write(0, 2, 0);
    do_tick();
    check("sq_v0", 32'(sample_out), 32'hBFFF);
    cfg_write(0, 1, 4);
    do_tick();
    check("sq_v0_vol4", 32'(sample_out), 32'h83FF);

    // Four squares saturate positive, then negative once phase enters the upper half.
    do_reset();
    for (int v = 0; v < NV; v++) begin
      cfg_write(v, 0, 'h10); cfg_write(v, 1, 0); cfg_write(v, 2, 0);
    end
    do_tick();
    check("sat_pos", 32'(sample_out), 32'hFFFF);
    while (m_phase[0] < 32768) do_tick();
    check("sat_neg", 32'(sample_out), 32'h0000);

    // Triangle on voice 1 through the phase wrap.
    do_reset();
    cfg_write(1, 2, 1); cfg_write(1, 0, 'h1FF); cfg_write(1, 1, 0);
    for (int i = 0; i < 128; i++) do_tick();
    check("tri_128", 32'(sample_out), 32'h407F);
    do_tick();
    check("tri_wrap", 32'(sample_out), 32'h417F);

    // Write collides with a sequence in progress: held until ready.
    cfg_write(0, 2, 0); cfg_write(0, 0, 'h40); cfg_write(0, 1, 1);
    @(posedge clk48); #1;
    sample_tick = 1'b1;
    exp_q.push_back(model_tick());
    @(posedge clk48); #1;
    sample_tick = 1'b0;
    repeat (2) @(posedge clk48);
    #1;
    cfg_we = 1'b1; cfg_voice = 2'd0; cfg_field = 2'd1; cfg_data = IW'(2);
    #1;
    check("coll_ready_low", 32'(cfg_ready), 32'd0);
    seen = 0; waited = 0;
    while (!cfg_ready && waited < 30) begin
      @(posedge clk48); #1; waited++;
      if (sample_valid) begin
        seen = 1;
        if (exp_q.size() > 0) check("coll_old_vol", 32'(sample_out), 32'(exp_q.pop_front()));
      end
    end
    check("coll_ready_seen", 32'(cfg_ready), 32'd1);
    check("coll_valid_seen", 32'(seen), 32'd1);
    @(posedge clk48); #1;
    cfg_we = 1'b0;
    m_vol[0] = 2;
    do_tick();

    // Second tick four cycles into a sequence.
    @(posedge clk48); #1;
    sample_tick = 1'b1;
    exp_q.push_back(model_tick());
    @(posedge clk48); #1;
    sample_tick = 1'b0;
    repeat (3) @(posedge clk48);
    #1; sample_tick = 1'b1;
    @(posedge clk48); #1;
    sample_tick = 1'b0;
    check("overrun_set", 32'(overrun), 32'd1);
    n = 0;
    repeat (20) begin
      @(posedge clk48); #1;
      if (sample_valid) begin
        n++;
        if (exp_q.size() > 0) check("overrun_sample", 32'(sample_out), 32'(exp_q.pop_front()));
      end
    end
    check("overrun_one_valid", 32'(n), 32'd1);
    do_tick();
    check("overrun_sticky", 32'(overrun), 32'd1);

    // Reset mid-sequence aborts without a sample.
    @(posedge clk48); #1;
    sample_tick = 1'b1;
    @(posedge clk48); #1;
    sample_tick = 1'b0;
    repeat (2) @(posedge clk48);
    do_reset();
    n = 0;
    repeat (15) begin
      @(posedge clk48); #1;
      if (sample_valid) n++;
    end
    check("abort_no_valid", 32'(n), 32'd0);
    do_tick();
    check("abort_silent", 32'(sample_out), 32'h8000);
    cfg_write(0, 0, 'h100); cfg_write(0, 1, 0); cfg_write(0, 2, 0);
    do_tick();
    check("abort_phase_reset", 32'(sample_out), 32'hBFFF);

    // Randomized config traffic interleaved with ticks.
    for (int it = 0; it < 60; it++) begin
      repeat ($urandom_range(0, 3))
        cfg_write($urandom_range(0, NV - 1), $urandom_range(0, 3), $urandom_range(0, (1 << IW) - 1));
      do_tick();
      repeat ($urandom_range(0, 5)) @(posedge clk48);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/voice_scheduler.md
# voice_scheduler

Time-multiplexed voice engine for the audio path: on each sample strobe it walks NVOICES oscillator voices through one shared phase adder and one shared waveform/attenuator. It accumulates the voice outputs into a saturated 16-bit offset-binary sample for the sigma-delta stage. A config write port lets the song logic set per-voice increment, volume and waveform. Writes are arbitrated against the sequencing so they never land mid-sample.

## Interface
- NVOICES, 4, number of voices (2..8); voice index width = clog2(NVOICES)
- INC_W, 9, phase-increment width; zero-extended into the 16-bit phase
- clk48  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- sample_tick  in  1  one-cycle pulse starting a sample period
- cfg_we  in  1  config write request
- cfg_voice  in  clog2(NVOICES)  target voice
- cfg_field  in  2  0=inc, 1=vol (cfg_data[3:0]), 2=wave (cfg_data[1:0]), 3=reserved (ignored)
- cfg_data  in  INC_W  write data
- cfg_ready  out  1  write accepted this cycle if cfg_we is high
- sample_out  out  16  unsigned sample (signed mix ^ 16'h8000)
- sample_valid  out  1  one-cycle pulse when sample_out is updated
- busy  out  1  sequencing in progress
- overrun  out  1  sticky: sample_tick arrived while busy

## Operation
- Per-voice registers:
  - phase[15:0]
  - inc[INC_W-1:0]
  - vol[3:0], an attenuation shift
  - wave[1:0]: 0=square, 1=triangle, 2=saw, 3=silent
- States: IDLE, PH(v), MIX(v), DONE.
  - IDLE + sample_tick -> PH(0); clear the 18-bit signed mix accumulator.
  - PH(v): phase[v] <= phase[v] + inc[v], mod 2^16 (wraps silently).
  - MIX(v): using the updated phase p, compute a signed 16-bit value w:
    - square: p[15] ? -16384 : +16383
    - triangle: (p ^ {16{p[15]}}) - 16384
    - saw: {1'b0,p[15:1]} - 16384
    - silent: 0
  - MIX(v), continued: mix += (w >>> vol[v]) (arithmetic, sign-extended to 18 bits); then -> PH(v+1), or DONE after the last voice.
  - DONE: saturate mix to [-32768, 32767]; sample_out <= sat ^ 16'h8000; pulse sample_valid; -> IDLE.
- busy = (state != IDLE).
- cfg_ready = (state == IDLE) & ~sample_tick (combinational).
  - A write with cfg_ready high updates the selected field at the clock edge.
  - A write with cfg_ready low is not applied. The requester holds cfg_we and data until it sees ready.
- sample_tick while busy is ignored. It sets overrun, and the sequence in progress is unaffected.
- sample_tick and cfg_we in the same IDLE cycle: the tick wins and the write waits.

## Timing
- Reset values (immediate, asynchronous):
  - state IDLE; all phase 0, inc 0, vol 15, wave 3
  - sample_out 16'h8000; sample_valid 0; busy 0; overrun 0
  - cfg_ready 1 (absent a tick)
- Tick sampled at edge k:
  - busy is high from k+1.
  - PH(v)/MIX(v) occupy edges k+1+2v / k+2+2v.
  - DONE updates sample_out and asserts sample_valid after edge k+2·NVOICES+1; this is 9 cycles for NVOICES=4.
  - busy is low, and cfg_ready may be high, after edge k+2·NVOICES+2.
- Minimum tick spacing: 2·NVOICES+2 cycles. The intended spacing is 1024 cycles.
- sample_out holds between sample_valid pulses.
- rst mid-sequence aborts immediately. No sample_valid is produced, and all registers return to their reset values.

## Test plan
- Reset, then 3 ticks spaced 1024 cycles (all voices silent) -> each sample_valid occurs exactly 9 cycles after its tick with sample_out=16'h8000; cfg_ready=1 while idle; overrun=0.
- Write v0 inc=0x100, vol=0, wave=0, then tick -> phase0=0x0100, sample_out=16'hBFFF. Set vol=4 and tick -> sample_out=16'h83FF (16383>>>4=1023).
- All 4 voices square, inc=0x10, vol=0, tick -> raw mix 65532 saturates -> sample_out=16'hFFFF. Set all to phase-in-negative-half by ticking until p[15]=1 -> mix -65536 saturates -> 16'h0000.
- Voice 1 triangle, inc=0x1FF, vol=0, others silent; 128 ticks -> phase=0xFF80, sample_out=16'h407F. Tick 129 -> phase wraps to 0x017F, sample_out=16'h417F.
- Two collision cases:
  - cfg_we (v0 vol=2) raised 3 cycles after a tick -> cfg_ready=0 and vol is unchanged until busy drops. The write lands on the first ready cycle, and the next sample reflects vol=2.
  - Second tick 4 cycles after the first -> overrun=1 (sticky), only one sample_valid.
- Tick, then rst asserted 3 cycles later -> no sample_valid; sample_out=16'h8000, busy=0, all voice registers at reset values. A tick after release yields 16'h8000.
